uart_rx: RTL and testbench

Serial receiver for the on-board UART link: it converts the 8N1 serial stream on `rx_in` back into bytes. It uses the same frame format and baud parameters as the transmitter, so the two form a loopback-capable pair. The line input is synchronised, start and stop bits are validated with a 3-sample majority vote at bit centre, and each good byte is delivered with a one-cycle `rx_valid` strobe. It sits between the board RX pin and the command/data consumer logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default clock/baud, frame shape and receiver states.
package uart_pkg;

  localparam int unsigned DEF_CLK_FRQ   = 27000000;
  localparam int unsigned DEF_BAUD_RATE = 3000000;
  localparam int unsigned DEF_CYCLE     = DEF_CLK_FRQ / DEF_BAUD_RATE;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin, plus a one-clock delayed
// copy used to detect the start-bit falling edge. All flops preset to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // synchronise the pin and keep the previous synchronised value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, 3-sample majority vote at bit centre,
// one-cycle rx_valid / rx_frame_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRQ   = DEF_CLK_FRQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CYCLE = CLK_FRQ / BAUD_RATE;
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CW    = $clog2(CYCLE);
  localparam int unsigned BW    = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST   = CW'(CYCLE - 1);
  localparam logic [CW-1:0] SAMPLE_A   = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMPLE_B   = CW'(HALF);
  localparam logic [CW-1:0] DECIDE_AT  = CW'(HALF + 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 fall;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [CW-1:0]        cycle_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic                 decide;
  logic                 start_frame;
  logic                 shift_en;
  logic                 valid_next;
  logic                 err_next;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign decide  = (cycle_cnt == DECIDE_AT);
  assign rx_busy = (state != S_IDLE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          start_frame = 1'b1;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (decide) state_next = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          valid_next = vote;
          err_next   = ~vote;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // bit-period and data-bit counters
  // The edge-detect cycle is position 0 of the start bit, so the counter
  // resumes at 1 to keep every bit boundary at E + k*CYCLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      bit_cnt   <= '0;
    end else if (start_frame) begin
      cycle_cnt <= CW'(1);
      bit_cnt   <= '0;
    end else if (state != S_IDLE) begin
      cycle_cnt <= (cycle_cnt == CNT_LAST) ? '0 : cycle_cnt + 1'b1;
      if (shift_en) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // first two majority samples around the bit centre
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state != S_IDLE) begin
      if (cycle_cnt == SAMPLE_A) samp_a <= rx_s;
      if (cycle_cnt == SAMPLE_B) samp_b <= rx_s;
    end
  end

  // shift register, delivered byte and registered strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= valid_next;
      rx_frame_err <= err_next;
      if (shift_en)   shreg   <= {vote, shreg[DATA_BITS-1:1]};
      if (valid_next) rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// checked against a frame-level timing/data reference model.
module tb_uart_rx;

  localparam int CLK_FRQ   = 27000000;
  localparam int BAUD_RATE = 3000000;
  localparam int CYC       = CLK_FRQ / BAUD_RATE;
  localparam int HLF       = CYC / 2;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned t;
    logic        v;
    logic        e;
    logic        busy;
    logic [7:0]  d;
  } ev_t;

  ev_t        seen[$];
  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx #(
    .CLK_FRQ   (CLK_FRQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every strobe cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_valid || rx_frame_err)
      seen.push_back('{t: cyc, v: rx_valid, e: rx_frame_err, busy: rx_busy, d: rx_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Drive one frame; flip one pin cycle at bit flip_k / centre offset, or
  // assert reset at the start of bit abort_k. The model predicts the strobe
  // at E + 9*CYC + HLF + 2 with E two clocks after the pin falls.
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int flip_k, input int abort_k);
    int unsigned t0;
    logic        bv;
    bit          aborted;
    t0 = 0;
    aborted = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bv = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      for (int j = 0; j < CYC; j++) begin
        @(negedge clk);
        if (k == 0 && j == 0) t0 = cyc;
        if (k == abort_k && j == 0) begin
          reset = 1'b1;
          aborted = 1'b1;
        end
        rx_in = (k == flip_k && j == HLF) ? ~bv : bv;
      end
    end
    if (aborted) begin
      last_good = 8'h00;
    end else if (stop) begin
      exp_q.push_back('{t: t0 + 2 + 9*CYC + HLF + 2, v: 1'b1, e: 1'b0, busy: 1'b0, d: b});
      last_good = b;
    end else begin
      exp_q.push_back('{t: t0 + 2 + 9*CYC + HLF + 2, v: 1'b0, e: 1'b1, busy: 1'b0, d: last_good});
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, ".count"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      check($sformatf("%s[%0d].time", tag, i), seen[i].t, exp_q[i].t);
      check($sformatf("%s[%0d].kind", tag, i), {seen[i].v, seen[i].e}, {exp_q[i].v, exp_q[i].e});
      check($sformatf("%s[%0d].busy", tag, i), seen[i].busy, exp_q[i].busy);
      check($sformatf("%s[%0d].data", tag, i), seen[i].d, exp_q[i].d);
    end
    seen.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0]  b;
    bit          st;
    int          gap;
    int unsigned g0;

    // reset, then idle-high line for 200 cycles
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle.outputs", {rx_data, rx_valid, rx_frame_err, rx_busy}, 11'h0);
    end

    // single byte at nominal rate
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(20);
    compare_events("a5");

    // back-to-back frames without idle gap
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(20);
    compare_events("b2b");

    // 2-cycle glitch is a false start
    @(negedge clk);
    g0 = cyc;
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    while (cyc < g0 + 3) @(negedge clk);
    check("glitch.busy_rise", rx_busy, 1'b1);
    while (cyc < g0 + 8) @(negedge clk);
    check("glitch.busy_fall", rx_busy, 1'b0);
    idle(20);
    // single inverted sample at centre of D3 is outvoted
    send_frame(8'h55, 1'b1, 4, -1);
    idle(20);
    compare_events("glitch55");

    // framing error then break, then recovery
    send_frame(8'h81, 1'b0, -1, -1);
    repeat (300) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    check("break.data_kept", rx_data, 8'h55);
    idle(20);
    send_frame(8'h42, 1'b1, -1, -1);
    idle(20);
    compare_events("break");

    // reset during D4 aborts the frame
    send_frame(8'h99, 1'b1, -1, 5);
    check("abort.in_reset", {rx_data, rx_valid, rx_frame_err, rx_busy}, 11'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    check("abort.after", {rx_data, rx_valid, rx_frame_err, rx_busy}, 11'h0);
    send_frame(8'h12, 1'b1, -1, -1);
    idle(20);
    compare_events("abort");

    // random bytes, random gaps, occasional bad stop bit
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom);
      st  = ($urandom_range(7) != 0);
      send_frame(b, st, -1, -1);
      gap = st ? int'($urandom_range(3)) : 2 + int'($urandom_range(5));
      if (gap > 0) idle(gap);
    end
    idle(20);
    compare_events("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
